// File: rtl/wsn_chan_pkg.sv
// Shared constants for the multi-node radio channel emulator.
// Collision modes, LFSR seed/taps and the LFSR step function.
package wsn_chan_pkg;

  localparam logic [1:0] MODE_OR    = 2'd0;
  localparam logic [1:0] MODE_IDLE  = 2'd1;
  localparam logic [1:0] MODE_NOISE = 2'd2;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 of a right-shifting register map to bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/wsn_chan_delay.sv
// Reset-to-idle shift chain with a selectable, registered output tap.
// Tap 0 bypasses the chain; tap d takes the sample from d cycles back.
module wsn_chan_delay #(
  parameter int          W       = 8,
  parameter int          SEL_W   = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic [W-1:0]     d_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic [W-1:0]     q_o
);

  localparam int DMAX = 2**SEL_W - 1;

  logic [W-1:0] chain_q [DMAX];
  logic [W-1:0] tap_d;
  logic [W-1:0] out_q;

  always_comb begin
    tap_d = d_i;
    if (sel_i != '0)
      tap_d = chain_q[sel_i - 1'b1];
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DMAX; i++)
        chain_q[i] <= RST_VAL;
      out_q <= RST_VAL;
    end else begin
      chain_q[0] <= d_i;
      for (int i = 1; i < DMAX; i++)
        chain_q[i] <= chain_q[i-1];
      out_q <= tap_d;
    end
  end

  assign q_o = out_q;

endmodule

// File: rtl/wsn_channel_model.sv
// N-node radio channel: masked all-to-all routing, collision
// resolution, selectable propagation delay and a collision counter.
import wsn_chan_pkg::*;

module wsn_channel_model #(
  parameter int   N_NODES    = 4,
  parameter int   DELAY_W    = 4,
  parameter int   CNT_W      = 16,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_NODES-1:0]           ant_tx,
  input  logic [N_NODES-1:0]           ant_en,
  input  logic [N_NODES*N_NODES-1:0]   link_mask,
  input  logic [DELAY_W-1:0]           delay_sel,
  input  logic [1:0]                   mode,
  input  logic                         clr_cnt,
  output logic [N_NODES-1:0]           ant_rx,
  output logic [N_NODES-1:0]           collision,
  output logic [CNT_W-1:0]             coll_cnt
);

  localparam int N = N_NODES;
  localparam logic [2*N-1:0] DLY_RST = {{N{1'b0}}, {N{IDLE_LEVEL}}};

  logic [N-1:0]   tx_q, en_q;
  logic [N*N-1:0] mask_q;
  logic [1:0]     mode_q;
  logic [15:0]    lfsr_q;
  logic [CNT_W-1:0] cnt_q;

  logic [N-1:0] bit_d, coll_d, act;
  logic         coll_any;
  logic [2*N-1:0] dly_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_q   <= '0;
      en_q   <= '0;
      mask_q <= '0;
      mode_q <= MODE_OR;
      lfsr_q <= LFSR_SEED;
    end else begin
      tx_q   <= ant_tx;
      en_q   <= ant_en;
      mask_q <= link_mask;
      mode_q <= mode;
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  always_comb begin
    bit_d  = {N{IDLE_LEVEL}};
    coll_d = '0;
    act    = '0;
    for (int r = 0; r < N; r++) begin
      for (int t = 0; t < N; t++)
        act[t] = (t != r) && en_q[t] && mask_q[t*N+r];
      if (act != '0) begin
        bit_d[r] = |(act & tx_q);
        // act & (act-1) is nonzero exactly when two or more bits are set
        if ((act & (act - 1'b1)) != '0) begin
          coll_d[r] = 1'b1;
          unique case (1'b1)
            (mode_q == MODE_IDLE):  bit_d[r] = IDLE_LEVEL;
            (mode_q == MODE_NOISE): bit_d[r] = lfsr_q[r % 16];
            default:                bit_d[r] = |(act & tx_q);
          endcase
        end
      end
    end
  end

  assign coll_any = |coll_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt_q <= '0;
    else if (clr_cnt)
      cnt_q <= '0;
    else if (coll_any && cnt_q != '1)
      cnt_q <= cnt_q + 1'b1;
  end

  wsn_chan_delay #(
    .W      (2*N),
    .SEL_W  (DELAY_W),
    .RST_VAL(DLY_RST)
  ) u_delay (
    .clk   (clk),
    .rst_ni(rst),
    .d_i   ({coll_d, bit_d}),
    .sel_i (delay_sel),
    .q_o   (dly_out)
  );

  assign ant_rx    = dly_out[N-1:0];
  assign collision = dly_out[2*N-1:N];
  assign coll_cnt  = cnt_q;

endmodule

// File: tb/tb_wsn_channel_model.sv
// Randomized + directed bench for wsn_channel_model against a
// cycle-indexed behavioural model of the channel.
module tb_wsn_channel_model;

  localparam int   N    = 4;
  localparam int   DW   = 4;
  localparam int   CW   = 4;
  localparam logic IDLE = 1'b0;
  localparam int   CMAX = 2**CW - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0]   ant_tx = '0;
  logic [N-1:0]   ant_en = '0;
  logic [N*N-1:0] link_mask = '1;
  logic [DW-1:0]  delay_sel = '0;
  logic [1:0]     mode = '0;
  logic           clr_cnt = 1'b0;
  logic [N-1:0]   ant_rx, collision;
  logic [CW-1:0]  coll_cnt;

  always #5 clk = ~clk;

  wsn_channel_model #(
    .N_NODES(N), .DELAY_W(DW), .CNT_W(CW), .IDLE_LEVEL(IDLE)
  ) dut (
    .clk(clk), .rst(rst),
    .ant_tx(ant_tx), .ant_en(ant_en),
    .link_mask(link_mask), .delay_sel(delay_sel),
    .mode(mode), .clr_cnt(clr_cnt),
    .ant_rx(ant_rx), .collision(collision),
    .coll_cnt(coll_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: hist[j] is the combined {coll,bit} seen during cycle j.
  logic [2*N-1:0] hist [64];
  int             cyc = 0;
  logic [15:0]    lfsr_m = 16'hACE1;
  int             cnt_m = 0;
  logic [2*N-1:0] idle_v;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  function automatic logic [2*N-1:0] channel(
    input logic [N-1:0] tx, input logic [N-1:0] en,
    input logic [N*N-1:0] mk, input logic [1:0] md,
    input logic [15:0] lf);
    logic [N-1:0] b, c;
    b = {N{IDLE}};
    c = '0;
    for (int r = 0; r < N; r++) begin
      int   k;
      logic orv;
      k = 0;
      orv = 1'b0;
      for (int t = 0; t < N; t++)
        if (t != r && en[t] && mk[t*N+r]) begin
          k++;
          orv = orv | tx[t];
        end
      if (k == 1) b[r] = orv;
      else if (k >= 2) begin
        c[r] = 1'b1;
        if (md == 2'd1)      b[r] = IDLE;
        else if (md == 2'd2) b[r] = lf[r % 16];
        else                 b[r] = orv;
      end
    end
    return {c, b};
  endfunction

  task automatic step();
    logic [2*N-1:0] o;
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 64; i++) hist[i] = idle_v;
      lfsr_m = 16'hACE1;
      cnt_m  = 0;
      o = idle_v;
    end else begin
      o = hist[(cyc - 1 - int'(delay_sel)) & 63];
      if (clr_cnt) cnt_m = 0;
      else if (|hist[(cyc - 1) & 63][2*N-1:N] && cnt_m < CMAX)
        cnt_m++;
      lfsr_m = lfsr_step(lfsr_m);
      hist[cyc & 63] = channel(ant_tx, ant_en, link_mask, mode, lfsr_m);
    end
    cyc++;
    #1;
    check("ant_rx", 32'(ant_rx), 32'(o[N-1:0]));
    check("collision", 32'(collision), 32'(o[2*N-1:N]));
    check("coll_cnt", 32'(coll_cnt), 32'(cnt_m));
  endtask

  task automatic pulse_pos(input logic [DW-1:0] d, input string tag);
    int pos;
    pos = -1;
    delay_sel = d; ant_en = 4'b0001; ant_tx = '0;
    mode = 2'd0; link_mask = '1;
    repeat (20) step();
    ant_tx = 4'b0001;
    for (int k = 1; k <= 25; k++) begin
      step();
      ant_tx = '0;
      if (ant_rx[2] && pos < 0) pos = k;
    end
    check(tag, 32'(pos), 32'(2 + int'(d)));
  endtask

  initial begin
    int nz;
    idle_v = {{N{1'b0}}, {N{IDLE}}};
    for (int i = 0; i < 64; i++) hist[i] = idle_v;
    #1;
    repeat (3) step();
    rst = 1'b1;

    // single transmitter, full mask incl. diagonal
    ant_en = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      ant_tx = 4'(i % 2 == 0);
      step();
    end
    ant_tx = 4'b0001;
    repeat (3) step();
    check("single_rx", 32'(ant_rx), 32'h0000000e);

    pulse_pos(4'd5, "dly5_pos");
    pulse_pos(4'd15, "dly15_pos");

    // two transmitters colliding, each mode
    delay_sel = '0;
    for (int m = 0; m < 3; m++) begin
      ant_en = '0; clr_cnt = 1'b1;
      step();
      clr_cnt = 1'b0;
      mode = 2'(m); ant_en = 4'b0011; ant_tx = 4'b0001;
      repeat (8) step();
      ant_en = '0;
      repeat (2) step();
      if (m == 0) check("coll8", 32'(coll_cnt), 32'd8);
    end

    // mask bit t=0 -> r=3 cleared
    mode = '0; ant_en = 4'b0001; link_mask = ~16'h0008;
    for (int i = 0; i < 6; i++) begin
      ant_tx = 4'(i % 2);
      step();
    end
    ant_tx = 4'b0001;
    repeat (2) step();
    check("mask_rx", 32'(ant_rx), 32'h00000006);

    // saturation, then clear in a collision cycle
    link_mask = '1; ant_en = 4'b0011;
    repeat (20) step();
    check("sat", 32'(coll_cnt), 32'(CMAX));
    clr_cnt = 1'b1;
    step();
    check("clr_pri", 32'(coll_cnt), 32'd0);
    clr_cnt = 1'b0;
    step();
    check("clr_next", 32'(coll_cnt), 32'd1);

    // async reset mid-stream with a loaded delay line
    delay_sel = 4'd7; ant_en = 4'b0111; ant_tx = 4'b0101;
    repeat (5) step();
    #2 rst = 1'b0;
    #1;
    check("rst_rx", 32'(ant_rx), 32'(idle_v[N-1:0]));
    check("rst_coll", 32'(collision), 32'd0);
    check("rst_cnt", 32'(coll_cnt), 32'd0);
    ant_en = '0;
    repeat (2) step();
    rst = 1'b1;
    nz = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ant_rx != idle_v[N-1:0] || collision != '0) nz++;
    end
    check("no_stale", 32'(nz), 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      ant_tx    = 4'($urandom);
      ant_en    = 4'($urandom);
      link_mask = 16'($urandom);
      mode      = 2'($urandom);
      clr_cnt   = ($urandom_range(31) == 0);
      if ($urandom_range(15) == 0) delay_sel = 4'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/wsn_channel_model.md
Name: wsn_channel_model

Overview:
- Synthesisable radio-channel emulator for multi-node simulation. It generalises the single-node antenna loopback to N nodes.
- Each node's antenna output (`ant_tx`, qualified by `ant_en`) is routed to every other node's `ant_rx`, subject to a per-link connectivity mask and a selectable propagation delay.
- Overlapping transmissions are resolved per a collision mode. Collisions are flagged and counted.
- Sits in the multi-SoC testbench between `system` instances, and can also be used on FPGA for multi-node demos.

Parameters:
- N_NODES, 4, number of nodes (2..16).
- DELAY_W, 4, width of `delay_sel`; delay line depth DMAX = 2**DELAY_W-1 cycles.
- CNT_W, 16, width of the collision counter.
- IDLE_LEVEL, 1'b0, `ant_rx` level when no transmitter reaches a receiver.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- ant_tx  in  N_NODES  antenna bit driven by each node.
- ant_en  in  N_NODES  node transmitter active.
- link_mask  in  N_NODES*N_NODES  bit [t*N_NODES+r]=1: tx t reaches rx r; diagonal ignored.
- delay_sel  in  DELAY_W  extra propagation delay in cycles (0..DMAX).
- mode  in  2  collision resolution: 0 OR, 1 force IDLE_LEVEL, 2 LFSR noise, 3 reserved (acts as 0).
- clr_cnt  in  1  synchronous clear of `coll_cnt`.
- ant_rx  out  N_NODES  received antenna bit per node.
- collision  out  N_NODES  receiver r saw two or more transmitters (aligned with `ant_rx`).
- coll_cnt  out  CNT_W  cycles with any collision, saturating.

Behaviour:
- Reset (rst=0, asynchronous):
  - `ant_rx` = {N{IDLE_LEVEL}}, `collision` = 0, `coll_cnt` = 0.
  - Delay line is filled with IDLE_LEVEL and collision bits 0.
  - LFSR = 16'hACE1.
- Stage 0 (input register): `ant_tx`, `ant_en`, `link_mask`, `mode` are registered every cycle.
- Combine, per receiver r, on the registered inputs:
  - Active set A_r = {t != r : en[t] & mask[t*N+r]}; k_r = |A_r|.
  - k_r=0: bit = IDLE_LEVEL, coll = 0.
  - k_r=1: bit = tx of the single member, coll = 0.
  - k_r>=2: coll = 1; bit = OR of tx over A_r (mode 0/3), IDLE_LEVEL (mode 1), or lfsr[r mod 16] (mode 2).
- Delay line:
  - The combined {bit, coll} vector shifts into a DMAX-deep register chain every cycle.
  - `delay_sel` selects the tap (0 = bypass chain).
  - The selected tap is registered into `ant_rx`/`collision`.
- Latency: input at edge n appears on `ant_rx` after edge n+2+delay_sel.
- Changing `delay_sel` mid-stream switches the tap immediately, without flushing. Samples are skipped (smaller value) or repeated from history (larger value). This is intended behaviour.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle after reset, independent of `mode`.
- coll_cnt:
  - Increments in the combine stage whenever OR(coll_r) = 1; it is not delayed.
  - Saturates at 2**CNT_W-1.
  - `clr_cnt` has priority over increment: a clear and a collision in the same cycle give 0.
- Self-transmission never loops back: receiver r ignores its own tx even when the mask diagonal is 1.
- Reset mid-operation: all state returns to reset values on the next evaluation, and in-flight delayed samples are discarded.
- No handshakes; the block is free-running and the output is valid every cycle after reset.

Decomposition:
- Package wsn_chan_pkg: mode constants MODE_OR=2'd0, MODE_IDLE=2'd1, MODE_NOISE=2'd2; LFSR_SEED=16'hACE1; LFSR tap constants.
- Sub-module wsn_chan_delay (width W, depth DMAX, tap select): reset-to-IDLE shift chain plus a registered output mux. Instantiated once with W = 2*N_NODES.

Test Plan:
- N=4, full mask, delay_sel=0, node0 en=1 toggling tx 1,0,1 -> `ant_rx[1..3]` show 1,0,1 starting 2 cycles later; `ant_rx[0]`=0; `collision`=0; `coll_cnt`=0.
- delay_sel=5, single tx pulse at cycle 10 -> `ant_rx[2]` pulses after edge 17 only; delay_sel=15 -> after edge 27.
- Nodes 0 and 1 both en, tx0=1, tx1=0, for 8 cycles:
  - mode0: `ant_rx[2]`=1, `collision[2]`=1, `coll_cnt`=8.
  - mode1: `ant_rx[2]`=0.
  - mode2: `ant_rx[2]` follows lfsr[2].
- link_mask clears bit [0*4+3], node0 transmitting alone -> `ant_rx[3]`=IDLE_LEVEL while `ant_rx[1]`/`ant_rx[2]` follow tx0; mask diagonal set -> `ant_rx[0]` unaffected.
- Counter: CNT_W=4 with 20 collision cycles -> `coll_cnt` saturates at 15; clr_cnt asserted in a collision cycle -> 0, then 1 on the next collision cycle.
- Assert rst low mid-stream with delay_sel=7 -> `ant_rx`=IDLE_LEVEL and `collision`=0 immediately; after release, no stale pulses emerge from the delay line.
